// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a one-entry holding register so back-to-back words stream gap-free.
// Optional even-parity trailer bit when PARITY_EN is defined.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
    localparam logic [CW-1:0] ONE  = CW'(1);
`ifdef PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    // Handshake: a word moves on a rising edge where data_valid && data_ready;
    // the producer holds data_in steady until then.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [CW-1:0]    cnt;
`ifdef PARITY_EN
    logic             par_bit;
`endif

    logic             accept;
    logic             final_bit;
    logic             load_now;
    logic [WIDTH-1:0] load_word;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] remaining(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign data_ready = reset & ~hold_full;
    assign busy       = (state != IDLE) | hold_full;
    assign accept     = data_valid & data_ready;

`ifdef PARITY_EN
    assign final_bit = (state == PAR);
`else
    assign final_bit = (state == SHIFT) && (cnt == LAST);
`endif

    // A held word always wins over a fresh one at the frame boundary; a fresh
    // word can only arrive there when hold is empty anyway.
    always_comb begin
        load_now  = 1'b0;
        load_word = data_in;
        if (state == IDLE) begin
            load_now = accept;
        end else if (final_bit) begin
            if (hold_full) begin
                load_now  = 1'b1;
                load_word = hold;
            end else begin
                load_now = accept;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            word_done  <= 1'b0;
`ifdef PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            if (load_now) begin
                state      <= SHIFT;
                dout       <= first_bit(load_word);
                shreg      <= remaining(load_word);
                cnt        <= ONE;
                dout_valid <= 1'b1;
                word_done  <= 1'b0;
`ifdef PARITY_EN
                par_bit    <= ^load_word;
`endif
                if (final_bit && hold_full) begin
                    hold_full <= 1'b0;
                end
            end else if (final_bit) begin
                state      <= IDLE;
                shreg      <= '0;
                cnt        <= '0;
                dout       <= 1'b0;
                dout_valid <= 1'b0;
                word_done  <= 1'b0;
            end else if (state == SHIFT) begin
`ifdef PARITY_EN
                if (cnt == LAST) begin
                    state     <= PAR;
                    dout      <= par_bit;
                    word_done <= 1'b1;
                end else
`endif
                begin
                    // cnt counts bits already presented, so it stops at WIDTH.
                    dout      <= first_bit(shreg);
                    shreg     <= remaining(shreg);
                    cnt       <= cnt + ONE;
                    word_done <= !PAR_ON && ((cnt + ONE) == LAST);
                end
            end

            if (accept && !load_now) begin
                hold      <= data_in;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: MSB-first and LSB-first instances share one stimulus stream.
module tb_bit_serializer;

    localparam int W = 8;
`ifdef PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME = W + PB;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         data_valid = 1'b0;
    logic         data_ready, dout, dout_valid, busy, word_done;
    logic         l_ready, l_dout, l_dout_valid, l_busy, l_word_done;

    int n_checks = 0;
    int n_fail = 0;
    logic [1:0] exp_m[$];
    logic [1:0] exp_l[$];
    int run_len = 0;
    int max_run = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .dout(dout), .dout_valid(dout_valid),
        .busy(busy), .word_done(word_done)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(l_ready), .dout(l_dout), .dout_valid(l_dout_valid),
        .busy(l_busy), .word_done(l_word_done)
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: data bits in the chosen order, then optional even parity.
    // Each entry is {bit, is_last_bit_of_frame}.
    task automatic push_frame(input logic [W-1:0] w);
        int ones;
        ones = 0;
        for (int i = 0; i < W; i++) begin
            exp_m.push_back({w[W-1-i], (i == W-1) && (PB == 0)});
            exp_l.push_back({w[i], (i == W-1) && (PB == 0)});
            ones += int'(w[i]);
        end
        if (PB == 1) begin
            exp_m.push_back({(ones % 2) == 1, 1'b1});
            exp_l.push_back({(ones % 2) == 1, 1'b1});
        end
    endtask

    // Stimulus observer: every accepted word becomes an expected frame; reset discards all.
    always @(posedge clk) begin
        if (!reset) begin
            exp_m.delete();
            exp_l.delete();
        end else if (data_valid && data_ready) begin
            push_frame(data_in);
        end
    end

    always @(negedge clk) begin
        logic [1:0] e;
        if (dout_valid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_m.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL msb_unexpected_bit: got dout=%b expected no valid bit at %0t", dout, $time);
            end else begin
                e = exp_m.pop_front();
                check_bit("msb_dout", dout, e[1]);
                check_bit("msb_word_done", word_done, e[0]);
                check_bit("msb_busy", busy, 1'b1);
            end
        end else begin
            run_len = 0;
            check_bit("msb_idle_dout", dout, 1'b0);
            check_bit("msb_idle_word_done", word_done, 1'b0);
        end
    end

    always @(negedge clk) begin
        logic [1:0] e;
        if (l_dout_valid) begin
            if (exp_l.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL lsb_unexpected_bit: got dout=%b expected no valid bit at %0t", l_dout, $time);
            end else begin
                e = exp_l.pop_front();
                check_bit("lsb_dout", l_dout, e[1]);
                check_bit("lsb_word_done", l_word_done, e[0]);
            end
        end else begin
            check_bit("lsb_idle_dout", l_dout, 1'b0);
            check_bit("lsb_idle_word_done", l_word_done, 1'b0);
        end
    end

    // Driver: called just after a negedge; returns just after the negedge following acceptance.
    task automatic send_word(input logic [W-1:0] w, output int waits);
        logic ok;
        waits = 0;
        data_in = w;
        data_valid = 1'b1;
        forever begin
            ok = data_ready;
            @(negedge clk);
            if (ok) break;
            waits++;
            if (waits >= 3 * FRAME + 8) begin
                check_bit("send_timeout", 1'b0, 1'b1);
                break;
            end
        end
        data_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_m.size() != 0 || exp_l.size() != 0 || dout_valid || busy || l_busy) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check_bit("drain_complete", t < 400, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits;
        int gap;

        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("reset_ready", data_ready, 1'b0);
        check_bit("reset_dout_valid", dout_valid, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_word_done", word_done, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_bit("post_reset_ready", data_ready, 1'b1);

        // Single word, then LSB-order pattern, then a parity pattern.
        send_word(8'h12, waits);
        check_int("single_wait", waits, 0);
        drain();
        send_word(8'h48, waits);
        drain();
        send_word(8'h13, waits);
        drain();

        // Back-to-back: one contiguous run of two frames.
        max_run = 0;
        send_word(8'h12, waits);
        send_word(8'h92, waits);
        check_int("b2b_second_wait", waits, 0);
        check_bit("b2b_ready_hold_full", data_ready, 1'b0);
        drain();
        check_int("b2b_run_length", max_run, 2 * FRAME);

        // Backpressure: third word stalls until the first frame ends.
        send_word(8'hC3, waits);
        send_word(8'h5A, waits);
        send_word(8'h81, waits);
        check_int("bp_third_wait", waits, FRAME - 1);
        drain();

        // Reset mid-frame with hold occupied.
        send_word(8'hA5, waits);
        send_word(8'h3C, waits);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_bit("midreset_ready_low", data_ready, 1'b0);
        check_bit("midreset_busy_before", busy, 1'b1);
        @(negedge clk);
        check_bit("midreset_dout_valid", dout_valid, 1'b0);
        check_bit("midreset_dout", dout, 1'b0);
        check_bit("midreset_word_done", word_done, 1'b0);
        check_bit("midreset_busy", busy, 1'b0);
        check_bit("midreset_ready", data_ready, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_bit("midreset_release_ready", data_ready, 1'b1);
        send_word(8'h12, waits);
        drain();

        // Randomized stream with random idle gaps (0 gives back-to-back offers).
        repeat (60) begin
            send_word(W'($urandom_range(0, (1 << W) - 1)), waits);
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
        end
        drain();
        check_bit("final_busy", busy, 1'b0);
        check_bit("final_ready", data_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
